// File: rtl/sarray_rd_arbiter_pkg.sv
// Shared widths and types for the systolic-array read-port arbiter.
// Defaults track ADDR_WIDTH, SARRAY_LOAD_WIDTH and SARRAY_RD_OUTST_DEPTH from the common header.
package sarray_rd_arbiter_pkg;

    localparam int SARRAY_ADDR_WIDTH     = 64;
    localparam int SARRAY_LOAD_WIDTH     = 2048;
    localparam int SARRAY_RD_OUTST_DEPTH = 8;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/sarray_rd_arbiter_if.sv
// One AR/R read channel. The side that issues requests uses master; the side that answers uses slave.
interface sarray_rd_arbiter_if
    import sarray_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = SARRAY_ADDR_WIDTH,
    parameter int DATA_WIDTH = SARRAY_LOAD_WIDTH
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data
    );
endinterface

// File: rtl/sarray_rd_arbiter_tag_fifo.sv
// In-order owner-id FIFO for outstanding reads.
// DEPTH must be a power of two, so the pointers wrap by plain overflow.
module rd_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     push_id,
    input  logic                     pop,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] tag_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = tag_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tag_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sarray_rd_arbiter.sv
// Round-robin arbiter sharing one memory AR/R channel between two load clients,
// returning each R beat to the requester that issued the matching AR.
//
// state     | meaning
// LOCK_IDLE | grant follows valids and round-robin priority
// LOCK_HELD | AR offered but not accepted; grant frozen to lock_id_q
module sarray_rd_arbiter
    import sarray_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = SARRAY_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SARRAY_LOAD_WIDTH,
    parameter int OUTST_DEPTH = SARRAY_RD_OUTST_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    sarray_rd_arbiter_if.slave           req0,
    sarray_rd_arbiter_if.slave           req1,
    sarray_rd_arbiter_if.master          mem,
    output logic [$clog2(OUTST_DEPTH):0] outst_cnt,
    output logic                         err
);
    lock_state_e           lock_q;
    lock_state_e           lock_d;
    logic                  lock_id_q;
    logic                  prio_q;
    logic                  grant_id;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_id;
    logic                  ar_hs;
    logic                  r_hs;
    logic [ADDR_WIDTH-1:0] ar_addr_sel;
    logic [DATA_WIDTH-1:0] r_data_bcast;

    always_comb begin
        grant_id = 1'b0;
        if (lock_q == LOCK_HELD)
            grant_id = lock_id_q;
        else if (req0.ar_valid && req1.ar_valid)
            grant_id = prio_q;
        else if (req1.ar_valid)
            grant_id = 1'b1;
    end

    assign ar_addr_sel   = grant_id ? req1.ar_addr : req0.ar_addr;
    assign mem.ar_addr   = ar_addr_sel;
    assign mem.ar_valid  = (req0.ar_valid | req1.ar_valid) & ~fifo_full;
    assign req0.ar_ready = ~grant_id & mem.ar_ready & ~fifo_full;
    assign req1.ar_ready =  grant_id & mem.ar_ready & ~fifo_full;
    assign ar_hs         = mem.ar_valid & mem.ar_ready;

    // Memory answers in AR order, so the FIFO head always names the beat's owner.
    assign req0.r_valid  = mem.r_valid & ~fifo_empty & ~head_id;
    assign req1.r_valid  = mem.r_valid & ~fifo_empty &  head_id;
    assign mem.r_ready   = ~fifo_empty & (head_id ? req1.r_ready : req0.r_ready);
    assign r_hs          = mem.r_valid & mem.r_ready;
    assign r_data_bcast  = mem.r_data;
    assign req0.r_data   = r_data_bcast;
    assign req1.r_data   = r_data_bcast;

    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            LOCK_IDLE: if (mem.ar_valid && !mem.ar_ready) lock_d = LOCK_HELD;
            LOCK_HELD: if (ar_hs) lock_d = LOCK_IDLE;
            default:   lock_d = LOCK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= LOCK_IDLE;
            lock_id_q <= 1'b0;
            prio_q    <= 1'b0;
            err       <= 1'b0;
        end else begin
            lock_q <= lock_d;
            if (lock_q == LOCK_IDLE && lock_d == LOCK_HELD)
                lock_id_q <= grant_id;
            if (ar_hs)
                prio_q <= other_id(grant_id);
            if (mem.r_valid && fifo_empty)
                err <= 1'b1;
        end
    end

    rd_tag_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ar_hs),
        .push_id (grant_id),
        .pop     (r_hs),
        .head    (head_id),
        .count   (outst_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
endmodule

// File: tb/tb_sarray_rd_arbiter.sv
// Directed bench for sarray_rd_arbiter: grant order, lock, full/backpressure, routing, error and reset.
module tb_sarray_rd_arbiter;
    import sarray_rd_arbiter_pkg::*;

    localparam int AW = SARRAY_ADDR_WIDTH;
    localparam int DW = SARRAY_LOAD_WIDTH;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] outst_cnt;
    logic       err;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sarray_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0_if ();
    sarray_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1_if ();
    sarray_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    sarray_rd_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .OUTST_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (r0_if),
        .req1      (r1_if),
        .mem       (mem_if),
        .outst_cnt (outst_cnt),
        .err       (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        r0_if.ar_valid  = 1'b0;
        r0_if.ar_addr   = '0;
        r0_if.r_ready   = 1'b0;
        r1_if.ar_valid  = 1'b0;
        r1_if.ar_addr   = '0;
        r1_if.r_ready   = 1'b0;
        mem_if.ar_ready = 1'b0;
        mem_if.r_valid  = 1'b0;
        mem_if.r_data   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [DW-1:0] beat(input int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i);
        return {64{w}};
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        checks++; if (outst_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", outst_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (mem_if.ar_valid !== 1'b0) begin failures++; $display("FAIL reset_ar_valid got=%b exp=0", mem_if.ar_valid); end
        checks++; if (mem_if.r_ready !== 1'b0) begin failures++; $display("FAIL reset_r_ready got=%b exp=0", mem_if.r_ready); end
        checks++; if ({r1_if.r_valid, r0_if.r_valid, r1_if.ar_ready, r0_if.ar_ready} !== 4'b0000) begin
            failures++; $display("FAIL reset_req_outs got=%b exp=0000", {r1_if.r_valid, r0_if.r_valid, r1_if.ar_ready, r0_if.ar_ready});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = {256{8'hA5}};
        r0_if.ar_valid  = 1'b1;
        r0_if.ar_addr   = 64'h1000;
        mem_if.ar_ready = 1'b1;
        #1;
        checks++; if (mem_if.ar_valid !== 1'b1) begin failures++; $display("FAIL single_ar_valid got=%b exp=1", mem_if.ar_valid); end
        checks++; if (mem_if.ar_addr !== 64'h1000) begin failures++; $display("FAIL single_ar_addr got=%0h exp=1000", mem_if.ar_addr); end
        checks++; if ({r1_if.ar_ready, r0_if.ar_ready} !== 2'b01) begin failures++; $display("FAIL single_ar_ready got=%b exp=01", {r1_if.ar_ready, r0_if.ar_ready}); end
        step();
        r0_if.ar_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd1) begin failures++; $display("FAIL single_cnt1 got=%0d exp=1", outst_cnt); end
        mem_if.r_valid = 1'b1;
        mem_if.r_data  = d;
        r0_if.r_ready  = 1'b1;
        #1;
        checks++; if ({r1_if.r_valid, r0_if.r_valid} !== 2'b01) begin failures++; $display("FAIL single_r_route got=%b exp=01", {r1_if.r_valid, r0_if.r_valid}); end
        checks++; if (r0_if.r_data !== d) begin failures++; $display("FAIL single_r_data got=%0h exp=%0h", r0_if.r_data[31:0], d[31:0]); end
        checks++; if (mem_if.r_ready !== 1'b1) begin failures++; $display("FAIL single_r_ready got=%b exp=1", mem_if.r_ready); end
        step();
        mem_if.r_valid = 1'b0;
        r0_if.r_ready  = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd0) begin failures++; $display("FAIL single_cnt0 got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_round_robin();
        int           n0;
        int           n1;
        logic         exp_id;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] d;
        n0 = 0;
        n1 = 0;
        do_reset();
        mem_if.ar_ready = 1'b1;
        r0_if.ar_valid  = 1'b1;
        r1_if.ar_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r0_if.ar_addr = 64'h2000 + 64'(n0 * 64);
            r1_if.ar_addr = 64'h3000 + 64'(n1 * 64);
            #1;
            exp_id   = (i % 2 == 1);
            exp_addr = exp_id ? 64'h3000 + 64'(n1 * 64) : 64'h2000 + 64'(n0 * 64);
            checks++; if (mem_if.ar_addr !== exp_addr) begin failures++; $display("FAIL rr_addr[%0d] got=%0h exp=%0h", i, mem_if.ar_addr, exp_addr); end
            checks++; if ({r1_if.ar_ready, r0_if.ar_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL rr_grant[%0d] got=%b exp_id=%0d", i, {r1_if.ar_ready, r0_if.ar_ready}, exp_id);
            end
            step();
            if (exp_id) n1++; else n0++;
        end
        r0_if.ar_valid = 1'b0;
        r1_if.ar_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd8) begin failures++; $display("FAIL rr_cnt8 got=%0d exp=8", outst_cnt); end
        mem_if.r_valid = 1'b1;
        r0_if.r_ready  = 1'b1;
        r1_if.r_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = beat(i);
            mem_if.r_data = d;
            #1;
            exp_id = (i % 2 == 1);
            checks++; if ({r1_if.r_valid, r0_if.r_valid} !== (exp_id ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL rr_r_route[%0d] got=%b exp_id=%0d", i, {r1_if.r_valid, r0_if.r_valid}, exp_id);
            end
            checks++; if ((exp_id ? r1_if.r_data : r0_if.r_data) !== d) begin failures++; $display("FAIL rr_r_data[%0d] exp=%0h", i, d[31:0]); end
            step();
        end
        mem_if.r_valid = 1'b0;
        r0_if.r_ready  = 1'b0;
        r1_if.r_ready  = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd0) begin failures++; $display("FAIL rr_cnt0 got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_full();
        do_reset();
        r0_if.ar_valid  = 1'b1;
        mem_if.ar_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r0_if.ar_addr = 64'h4000 + 64'(i * 64);
            #1;
            checks++; if (r0_if.ar_ready !== 1'b1) begin failures++; $display("FAIL full_fill_ready[%0d] got=%b exp=1", i, r0_if.ar_ready); end
            step();
        end
        checks++; if (outst_cnt !== 4'd8) begin failures++; $display("FAIL full_cnt8 got=%0d exp=8", outst_cnt); end
        checks++; if (r0_if.ar_ready !== 1'b0) begin failures++; $display("FAIL full_ready9 got=%b exp=0", r0_if.ar_ready); end
        checks++; if (mem_if.ar_valid !== 1'b0) begin failures++; $display("FAIL full_ar_valid got=%b exp=0", mem_if.ar_valid); end
        mem_if.r_valid = 1'b1;
        mem_if.r_data  = beat(100);
        r0_if.r_ready  = 1'b1;
        #1;
        checks++; if (mem_if.r_ready !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b exp=1", mem_if.r_ready); end
        checks++; if (r0_if.ar_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass got=%b exp=0", r0_if.ar_ready); end
        step();
        mem_if.r_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd7) begin failures++; $display("FAIL full_cnt7 got=%0d exp=7", outst_cnt); end
        checks++; if (r0_if.ar_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", r0_if.ar_ready); end
        step();
        r0_if.ar_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd8) begin failures++; $display("FAIL full_refill got=%0d exp=8", outst_cnt); end
        mem_if.r_valid = 1'b1;
        repeat (8) step();
        mem_if.r_valid = 1'b0;
        r0_if.r_ready  = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_lock();
        do_reset();
        r1_if.ar_valid  = 1'b1;
        r1_if.ar_addr   = 64'h5000;
        mem_if.ar_ready = 1'b0;
        #1;
        checks++; if (mem_if.ar_addr !== 64'h5000) begin failures++; $display("FAIL lock_first_addr got=%0h exp=5000", mem_if.ar_addr); end
        step();
        r0_if.ar_valid = 1'b1;
        r0_if.ar_addr  = 64'h6000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_if.ar_addr !== 64'h5000) begin failures++; $display("FAIL lock_hold_addr[%0d] got=%0h exp=5000", i, mem_if.ar_addr); end
            checks++; if (mem_if.ar_valid !== 1'b1) begin failures++; $display("FAIL lock_hold_valid[%0d] got=%b exp=1", i, mem_if.ar_valid); end
            step();
        end
        mem_if.ar_ready = 1'b1;
        #1;
        checks++; if ({r1_if.ar_ready, r0_if.ar_ready} !== 2'b10) begin failures++; $display("FAIL lock_hs_grant got=%b exp=10", {r1_if.ar_ready, r0_if.ar_ready}); end
        checks++; if (mem_if.ar_addr !== 64'h5000) begin failures++; $display("FAIL lock_hs_addr got=%0h exp=5000", mem_if.ar_addr); end
        step();
        r1_if.ar_addr = 64'h5040;
        #1;
        checks++; if (mem_if.ar_addr !== 64'h6000) begin failures++; $display("FAIL lock_next_addr got=%0h exp=6000", mem_if.ar_addr); end
        checks++; if ({r1_if.ar_ready, r0_if.ar_ready} !== 2'b01) begin failures++; $display("FAIL lock_next_grant got=%b exp=01", {r1_if.ar_ready, r0_if.ar_ready}); end
        step();
        r0_if.ar_valid  = 1'b0;
        r1_if.ar_valid  = 1'b0;
        mem_if.ar_ready = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd2) begin failures++; $display("FAIL lock_cnt got=%0d exp=2", outst_cnt); end
    endtask

    // Continues from test_lock: FIFO holds req1 then req0.
    task automatic test_r_stall();
        mem_if.r_valid = 1'b1;
        mem_if.r_data  = beat(7);
        r1_if.r_ready  = 1'b0;
        r0_if.r_ready  = 1'b1;
        #1;
        checks++; if (mem_if.r_ready !== 1'b0) begin failures++; $display("FAIL stall_r_ready got=%b exp=0", mem_if.r_ready); end
        checks++; if ({r1_if.r_valid, r0_if.r_valid} !== 2'b10) begin failures++; $display("FAIL stall_route got=%b exp=10", {r1_if.r_valid, r0_if.r_valid}); end
        step();
        step();
        checks++; if (outst_cnt !== 4'd2) begin failures++; $display("FAIL stall_no_pop got=%0d exp=2", outst_cnt); end
        r1_if.r_ready = 1'b1;
        #1;
        checks++; if (mem_if.r_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", mem_if.r_ready); end
        step();
        r1_if.r_ready = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd1) begin failures++; $display("FAIL stall_cnt1 got=%0d exp=1", outst_cnt); end
        checks++; if ({r1_if.r_valid, r0_if.r_valid} !== 2'b01) begin failures++; $display("FAIL stall_next_route got=%b exp=01", {r1_if.r_valid, r0_if.r_valid}); end
        step();
        mem_if.r_valid = 1'b0;
        r0_if.r_ready  = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd0) begin failures++; $display("FAIL stall_cnt0 got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_error_and_reset();
        mem_if.r_valid = 1'b1;
        r0_if.r_ready  = 1'b1;
        r1_if.r_ready  = 1'b1;
        #1;
        checks++; if (mem_if.r_ready !== 1'b0) begin failures++; $display("FAIL err_r_ready got=%b exp=0", mem_if.r_ready); end
        checks++; if ({r1_if.r_valid, r0_if.r_valid} !== 2'b00) begin failures++; $display("FAIL err_r_valid got=%b exp=00", {r1_if.r_valid, r0_if.r_valid}); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err); end
        step();
        mem_if.r_valid = 1'b0;
        r0_if.r_ready  = 1'b0;
        r1_if.r_ready  = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err); end
        repeat (3) step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
        r0_if.ar_valid  = 1'b1;
        r0_if.ar_addr   = 64'h7000;
        mem_if.ar_ready = 1'b1;
        step();
        step();
        r0_if.ar_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd2) begin failures++; $display("FAIL midrst_pre_cnt got=%0d exp=2", outst_cnt); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", outst_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", err); end
        step();
        rst_n = 1'b1;
        r0_if.ar_valid = 1'b1;
        r0_if.ar_addr  = 64'h8000;
        r1_if.ar_valid = 1'b1;
        r1_if.ar_addr  = 64'h9000;
        #1;
        checks++; if (mem_if.ar_addr !== 64'h8000) begin failures++; $display("FAIL midrst_prio got=%0h exp=8000", mem_if.ar_addr); end
        step();
        r0_if.ar_valid = 1'b0;
        r1_if.ar_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 4'd1) begin failures++; $display("FAIL midrst_post_cnt got=%0d exp=1", outst_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_lock();
        test_r_stall();
        test_error_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
